// File: rtl/dmem_responder_pkg.sv
// Shared data-bus types for the memory stage and its data-memory responder.
// Holds the request/response payload structs, the bus widths they are sized
// for, and the responder FSM state encodings.
package dmem_responder_pkg;

  localparam int unsigned DMEM_ADDR_W = 64;
  localparam int unsigned DMEM_DATA_W = 64;
  localparam int unsigned DMEM_STRB_W = DMEM_DATA_W / 8;

  // Responder FSM encodings (IDLE, WAIT, RESP)
  localparam logic [1:0] DMEM_IDLE = 2'd0;
  localparam logic [1:0] DMEM_WAIT = 2'd1;
  localparam logic [1:0] DMEM_RESP = 2'd2;

  typedef struct packed {
    logic                   write;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_STRB_W-1:0] strobe;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic [DMEM_DATA_W-1:0] rdata;
    logic                   err;
  } dmem_resp_t;

endpackage

// File: rtl/dmem_responder_ram.sv
// Byte-enabled word array behind the data-memory responder.
// Ports: clk; we/waddr/wstrobe/wdata = synchronous byte-masked write;
//        raddr/rdata = asynchronous read (the caller registers rdata).
// Contents are deliberately not reset.
module dmem_responder_ram #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W/8-1:0]      wstrobe,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Byte-lane masked write
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrobe[b]) mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: far end of the memory-stage data bus.
// One outstanding load/store, fixed LATENCY from acceptance to response.
// Ports: clk, rst (async, active-low);
//        req_valid/req_ready/req_write/req_addr/req_strobe/req_wdata = request channel;
//        resp_valid/resp_ready/resp_rdata/resp_err = response channel.
// Stores commit on the acceptance edge; loads read the array on the edge
// that enters RESP, so they always see every earlier store.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W/8-1:0] req_strobe,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [DMEM_ADDR_W-1:0] ADDR_LIMIT = DMEM_ADDR_W'(DEPTH * STRB_W);

  // Request payload as seen on the bus this cycle
  dmem_req_t req_c;
  assign req_c.write  = req_write;
  assign req_c.addr   = DMEM_ADDR_W'(req_addr);
  assign req_c.strobe = DMEM_STRB_W'(req_strobe);
  assign req_c.wdata  = DMEM_DATA_W'(req_wdata);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             write_q, write_d;
  logic             err_q, err_d;
  dmem_resp_t       resp_q, resp_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;

  logic             accept_c;
  logic             err_c;
  logic [IDX_W-1:0] idx_c;
  logic [IDX_W-1:0] rd_idx_c;
  logic [DATA_W-1:0] ram_rdata;
  logic             unused_addr_c;

  assign accept_c = req_valid & req_ready_q;
  assign err_c    = (req_c.addr >= ADDR_LIMIT);
  assign idx_c    = req_c.addr[OFF_W +: IDX_W];
  // Sub-word offset bits never select anything
  assign unused_addr_c = ^req_c.addr[OFF_W-1:0];

  // With LATENCY==1 the read happens on the acceptance edge, so read the live index
  assign rd_idx_c = (state_q == DMEM_IDLE) ? idx_c : idx_q;

  dmem_responder_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (accept_c & req_c.write & ~err_c),
    .waddr   (idx_c),
    .wstrobe (STRB_W'(req_c.strobe)),
    .wdata   (DATA_W'(req_c.wdata)),
    .raddr   (rd_idx_c),
    .rdata   (ram_rdata)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    write_d      = write_q;
    err_d        = err_q;
    resp_d       = resp_q;

    case (state_q)
      DMEM_IDLE: begin
        if (accept_c) begin
          idx_d   = idx_c;
          write_d = req_c.write;
          err_d   = err_c;
          if (LATENCY == 1) begin
            state_d      = DMEM_RESP;
            resp_d.err   = err_c;
            resp_d.rdata = (req_c.write | err_c) ? '0 : DMEM_DATA_W'(ram_rdata);
          end else begin
            state_d = DMEM_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      DMEM_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Counter reaches zero on this edge: capture the load word now
        if (cnt_q == CNT_W'(1)) begin
          state_d      = DMEM_RESP;
          resp_d.err   = err_q;
          resp_d.rdata = (write_q | err_q) ? '0 : DMEM_DATA_W'(ram_rdata);
        end
      end
      DMEM_RESP: begin
        if (resp_ready) begin
          state_d = DMEM_IDLE;
          resp_d  = '0;
        end
      end
      default: begin
        state_d = DMEM_IDLE;
        resp_d  = '0;
      end
    endcase

    req_ready_d  = (state_d == DMEM_IDLE);
    resp_valid_d = (state_d == DMEM_RESP);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= DMEM_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      resp_q       <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      write_q      <= write_d;
      err_q        <= err_d;
      resp_q       <= resp_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = DATA_W'(resp_q.rdata);
  assign resp_err   = resp_q.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (ADDR_W=64, DATA_W=64, DEPTH=512, LATENCY=2).
module tb_dmem_responder;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [7:0]  req_strobe = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int passed = 0;
  int unsigned cyc = 0;

  dmem_responder #(
    .ADDR_W  (64),
    .DATA_W  (64),
    .DEPTH   (512),
    .LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_strobe (req_strobe),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One full transaction with resp_ready held high; called just after a negedge.
  task automatic xact(input logic w, input logic [63:0] a, input logic [7:0] s,
                      input logic [63:0] d, output logic [63:0] rd, output logic e,
                      output int lat, output int unsigned acc);
    req_write  = w;
    req_addr   = a;
    req_strobe = s;
    req_wdata  = d;
    req_valid  = 1'b1;
    resp_ready = 1'b1;
    for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    e  = resp_err;
    @(negedge clk);
  endtask

  logic [63:0] rd;
  logic        e;
  int          lat;
  int unsigned acc1, acc2;

  initial begin
    // Reset held: outputs quiet
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Preload words 0x0 and 0x10 through the bus
    xact(1'b1, 64'h0, 8'hFF, 64'h1122334455667788, rd, e, lat, acc1);
    chk("preload_err", 64'(e), 64'd0);
    chk("preload_store_rdata", rd, 64'd0);
    chk("store_latency", 64'(lat), 64'(LAT));
    xact(1'b1, 64'h10, 8'hFF, 64'h0, rd, e, lat, acc1);

    // Basic load
    xact(1'b0, 64'h0, 8'h00, 64'h0, rd, e, lat, acc1);
    chk("load0_rdata", rd, 64'h1122334455667788);
    chk("load0_err", 64'(e), 64'd0);
    chk("load0_latency", 64'(lat), 64'(LAT));
    chk("after_hs_valid", 64'(resp_valid), 64'd0);
    chk("after_hs_ready", 64'(req_ready), 64'd1);

    // Partial store, low four bytes only
    xact(1'b1, 64'h10, 8'h0F, 64'hAAAAAAAAAAAAAAAA, rd, e, lat, acc1);
    xact(1'b0, 64'h10, 8'h00, 64'h0, rd, e, lat, acc1);
    chk("partial_rdata", rd, 64'h00000000AAAAAAAA);

    // Back-to-back store then load
    xact(1'b1, 64'h18, 8'hFF, 64'hDEADBEEF00000001, rd, e, lat, acc1);
    xact(1'b0, 64'h18, 8'h00, 64'h0, rd, e, lat, acc2);
    chk("b2b_accept_gap", 64'(acc2 - acc1), 64'(LAT + 1));
    chk("b2b_rdata", rd, 64'hDEADBEEF00000001);

    // Response backpressure for 5 cycles
    req_write = 1'b0;
    req_addr  = 64'h18;
    req_valid = 1'b1;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_rdata", resp_rdata, 64'hDEADBEEF00000001);
      chk("bp_err", 64'(resp_err), 64'd0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 64'(resp_valid), 64'd0);
    chk("bp_release_rdata", resp_rdata, 64'd0);
    @(negedge clk);
    chk("bp_single_hs", 64'(resp_valid), 64'd0);

    // Out-of-range store: error, no write
    xact(1'b1, 64'h1000, 8'hFF, 64'hFFFFFFFFFFFFFFFF, rd, e, lat, acc1);
    chk("oor_store_err", 64'(e), 64'd1);
    chk("oor_store_rdata", rd, 64'd0);
    xact(1'b0, 64'h0, 8'h00, 64'h0, rd, e, lat, acc1);
    chk("oor_word0_intact", rd, 64'h1122334455667788);
    xact(1'b0, 64'hFF8, 8'h00, 64'h0, rd, e, lat, acc1);
    chk("last_word_err", 64'(e), 64'd0);
    xact(1'b0, 64'h1008, 8'h00, 64'h0, rd, e, lat, acc1);
    chk("oor_load_err", 64'(e), 64'd1);
    chk("oor_load_rdata", rd, 64'd0);

    // Zero strobe store writes nothing but still responds
    xact(1'b1, 64'h0, 8'h00, 64'h0, rd, e, lat, acc1);
    chk("zstrb_latency", 64'(lat), 64'(LAT));
    chk("zstrb_err", 64'(e), 64'd0);
    xact(1'b0, 64'h0, 8'h00, 64'h0, rd, e, lat, acc1);
    chk("zstrb_word0", rd, 64'h1122334455667788);

    // Low address bits do not affect word select
    xact(1'b0, 64'h13, 8'h00, 64'h0, rd, e, lat, acc1);
    chk("offset_ignored", rd, 64'h00000000AAAAAAAA);

    // Reset during WAIT
    req_write = 1'b0;
    req_addr  = 64'h0;
    req_valid = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_wait_valid", 64'(resp_valid), 64'd0);
    chk("rst_wait_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_ready_after", 64'(req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("rst_wait_no_stale", 64'(resp_valid), 64'd0);
      @(negedge clk);
    end

    // Reset during RESP drops the response at once
    req_addr  = 64'h18;
    req_valid = 1'b1;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_resp_pre_valid", 64'(resp_valid), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata_clr", resp_rdata, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("rst_resp_ready_after", 64'(req_ready), 64'd1);
    chk("rst_resp_no_stale", 64'(resp_valid), 64'd0);

    // Stores survive reset
    xact(1'b0, 64'h10, 8'h00, 64'h0, rd, e, lat, acc1);
    chk("post_rst_word10", rd, 64'h00000000AAAAAAAA);
    xact(1'b0, 64'h18, 8'h00, 64'h0, rd, e, lat, acc1);
    chk("post_rst_word18", rd, 64'hDEADBEEF00000001);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that answers load/store requests issued by the pipeline's memory stage over a valid/ready request channel and a valid/ready response channel.
- Backed by an internal byte-writable word array.
- At most one outstanding transaction. Fixed, parameterised access latency.
- Serves as the far end of the data bus, so the memory stage's load/store path can be built and verified against it.

Parameters:
- ADDR_W, 64, request address width in bits.
- DATA_W, 64, data width in bits; the strobe is DATA_W/8 bits wide.
- DEPTH, 512, number of DATA_W words in the array; must be a power of two.
- LATENCY, 2, cycles from request acceptance to resp_valid assertion; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low: asserting rst=0 immediately forces the reset state.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address; bits [2:0] ignored for word select.
- req_strobe  in  DATA_W/8  byte enables for stores; ignored for loads.
- req_wdata  in  DATA_W  store data, byte-lane aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester consumes the response.
- resp_rdata  out  DATA_W  full load word; 0 for stores and errors.
- resp_err  out  1  address out of range.

Behaviour:
- Reset (rst=0, async) outputs:
  - req_ready=0 while asserted, then 1 on the first cycle after release.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - FSM goes to IDLE, latency counter cleared, any in-flight transaction dropped.
  - Array contents are not reset; a store already committed stays committed.
- FSM IDLE:
  - req_ready=1.
  - Handshake on req_valid&req_ready: latch write, address, strobe and wdata; compute err = (req_addr >= DEPTH*DATA_W/8).
  - Load counter with LATENCY-1 and go to WAIT. If LATENCY==1, go directly to RESP.
- Stores commit on the acceptance edge:
  - Only bytes whose strobe bit is 1 are written.
  - No write occurs if err=1.
  - A strobe of all zeros is legal, writes nothing, and still yields a response.
- FSM WAIT:
  - req_ready=0.
  - Counter decrements each cycle; on the cycle it reaches 0, go to RESP.
- Load data capture:
  - Data is read from the array on the WAIT→RESP (or IDLE→RESP) edge and registered into resp_rdata.
  - This means a load always observes every store accepted earlier.
- FSM RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until the handshake.
  - req_ready=0.
  - On resp_ready=1, go to IDLE the next cycle and clear resp_valid, resp_rdata and resp_err.
- Latency: request accepted at edge N gives resp_valid high from cycle N+LATENCY.
- Throughput: one transaction per LATENCY+1 cycles minimum, since no request is accepted in the cycle the response retires.
- req_valid must not depend on req_ready (no combinational loop). Request inputs are sampled only on the handshake edge.
- resp_ready held high before resp_valid is legal; it completes the handshake on the first RESP cycle.
- Address handling: word index = req_addr[log2(DEPTH)+2:3]. No wrap-around; out-of-range addresses produce an err response only.
- Async reset is legal in any state, including mid-WAIT or mid-RESP. The response is lost and the requester must reissue.

Decomposition:
- Shared package (common), in the same place as the pipeline stage register structs:
  - DMEM_REQ struct: write, addr, strobe, wdata.
  - DMEM_RESP struct: rdata, err.
  - Enum DMEM_STATE {IDLE, WAIT, RESP}.
- One sub-module, dmem_ram:
  - Synchronous-write, byte-enabled word array: clk, we, waddr, wstrobe, wdata, raddr, rdata.
  - Asynchronous read; the responder registers the read output.
  - No reset port.

Test Plan:
- Reset and basic load: release reset, then load addr 0x0 → req_ready=1 in the cycle after release; resp_valid at accept+2 with resp_rdata=X initial contents (bench preloads 0x1122334455667788), resp_err=0.
- Partial store: store addr 0x10, wdata 0xAAAAAAAAAAAAAAAA, strobe 0x0F; then load 0x10 (pre-filled 0) → load returns 0x00000000AAAAAAAA.
- Back-to-back: store 0x18=0xDEADBEEF00000001 with strobe 0xFF, immediately followed by load 0x18 → second request accepted exactly LATENCY+1 cycles after the first; load returns 0xDEADBEEF00000001.
- Response backpressure: load with resp_ready held 0 for 5 cycles → resp_valid, resp_rdata and resp_err stable for all 5 cycles; req_ready=0 throughout; one handshake only.
- Out-of-range: store to addr DEPTH*8 (0x1000) with strobe 0xFF, then load 0x0 → store response has resp_err=1 and rdata=0; word 0 is unchanged.
- Reset mid-operation: assert rst=0 during WAIT of a load → resp_valid=0 immediately; after release no stale response appears and req_ready=1; earlier stores remain readable.
